approx_div: RTL and testbench

APPROX_DIV -- requirements
Module: approx_div

---
 rtl/approx_div_pkg.sv | 15 +
 rtl/div_step.sv | 28 ++
 rtl/approx_div.sv | 136 +++++++++++++
 tb/tb_approx_div.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/approx_div_pkg.sv
// Shared types and defaults for the approximate/exact restoring divider.
// Holds the controller state encoding and the default width constants.
// Imported by approx_div and div_step.
package approx_div_pkg;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_APPROX_BITS = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit, compare, conditionally subtract.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; evaluated every cycle by the owning controller.
// Ports: prem_in/prem_out - WIDTH+1 bit partial remainder; dbit - next dividend bit;
//        divisor - WIDTH bit divisor; qbit - resulting quotient bit.
module div_step
  import approx_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   prem_in,
  input  logic             dbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   prem_out,
  output logic             qbit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH:0]   diff;

  // Kept one bit wider than the partial remainder so the compare never truncates.
  assign shifted  = {prem_in, dbit};
  assign qbit     = (shifted >= {2'b00, divisor});
  // When qbit is set the difference is < divisor, so the low WIDTH+1 bits are exact.
  assign diff     = shifted[WIDTH:0] - {1'b0, divisor};
  assign prem_out = qbit ? diff : shifted[WIDTH:0];

endmodule

// File: rtl/approx_div.sv
// Unsigned 2W/W restoring divider with divide-by-zero and overflow short-cuts.
// Latency: 1 cycle for zero/overflow, ITERS+1 cycles otherwise (ITERS = WIDTH, or WIDTH-APPROX_BITS).
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, no same-cycle re-accept.
// Ports: clk, rst_n (async active-low); in_valid/in_ready with dividend[2W], divisor[W];
//        out_valid/out_ready with quotient[W], remainder[W], div_by_zero, overflow.
// Build option: define DIV_APPROX_EN to skip the low APPROX_BITS quotient bits (remainder reads 0).
module approx_div
  import approx_div_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int APPROX_BITS = DEF_APPROX_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2*WIDTH-1:0]   dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     quotient,
  output logic [WIDTH-1:0]     remainder,
  output logic                 div_by_zero,
  output logic                 overflow
);

`ifdef DIV_APPROX_EN
  localparam bit APPROX_EN = 1'b1;
`else
  localparam bit APPROX_EN = 1'b0;
`endif

  localparam int DROP  = APPROX_EN ? APPROX_BITS : 0;
  localparam int ITERS = WIDTH - DROP;
  localparam int CW    = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [WIDTH:0]   prem_q, prem_nxt;
  logic [WIDTH-1:0] dlo_q;
  logic [WIDTH-1:0] qacc_q, qacc_nxt;
  logic [WIDTH-1:0] div_q;
  logic [CW-1:0]    cnt_q;
  logic             qbit;
  logic             accept;
  logic             is_dbz;
  logic             is_ovf;
  logic             last_iter;

  assign accept    = in_valid && (state_q == IDLE);
  assign is_dbz    = (divisor == '0);
  // A high half >= divisor means the true quotient does not fit in WIDTH bits.
  assign is_ovf    = !is_dbz && (dividend[2*WIDTH-1:WIDTH] >= divisor);
  assign last_iter = (cnt_q == CW'(ITERS - 1));
  assign qacc_nxt  = {qacc_q[WIDTH-2:0], qbit};

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .prem_in  (prem_q),
    .dbit     (dlo_q[WIDTH-1]),
    .divisor  (div_q),
    .prem_out (prem_nxt),
    .qbit     (qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = (is_dbz || is_ovf) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prem_q      <= '0;
      dlo_q       <= '0;
      qacc_q      <= '0;
      div_q       <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else if (accept) begin
      div_q       <= divisor;
      prem_q      <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
      dlo_q       <= dividend[WIDTH-1:0];
      qacc_q      <= '0;
      cnt_q       <= '0;
      div_by_zero <= is_dbz;
      overflow    <= is_ovf;
      if (is_dbz || is_ovf) begin
        quotient  <= '1;
        remainder <= dividend[WIDTH-1:0];
      end
    end else if (state_q == RUN) begin
      prem_q <= prem_nxt;
      dlo_q  <= {dlo_q[WIDTH-2:0], 1'b0};
      qacc_q <= qacc_nxt;
      cnt_q  <= cnt_q + 1'b1;
      if (last_iter) begin
        // Collected bits sit in the low ITERS positions; realign to the true weight.
        quotient  <= qacc_nxt << DROP;
        remainder <= APPROX_EN ? '0 : prem_nxt[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_approx_div.sv
// Directed bench for approx_div: reset, exact/approx results, zero and overflow paths,
// backpressure hold, boundary operands, and reset in the middle of a division.
module tb_approx_div;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        div_by_zero;
  logic        overflow;

  int nchk  = 0;
  int nfail = 0;
  int lat;

`ifdef DIV_APPROX_EN
  localparam int          LAT_N = 11;
  localparam logic [15:0] Q_A   = 16'd128;
  localparam logic [15:0] R_A   = 16'd0;
  localparam logic [15:0] Q_B   = 16'h1B00;
  localparam logic [15:0] R_B   = 16'h0000;
  localparam logic [15:0] Q_M   = 16'hFFC0;
  localparam logic [15:0] R_M   = 16'h0000;
`else
  localparam int          LAT_N = 17;
  localparam logic [15:0] Q_A   = 16'd142;
  localparam logic [15:0] R_A   = 16'd6;
  localparam logic [15:0] Q_B   = 16'h1B20;
  localparam logic [15:0] R_B   = 16'h3DD8;
  localparam logic [15:0] Q_M   = 16'hFFFF;
  localparam logic [15:0] R_M   = 16'hFFFE;
`endif

  approx_div #(
    .WIDTH       (16),
    .APPROX_BITS (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Presents one operand pair, then counts cycles until out_valid (0 = never seen).
  task automatic run_op(input logic [31:0] dd, input logic [15:0] ds, output int l);
    @(negedge clk);
    chk("accept_rdy", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    dividend = dd;
    divisor  = ds;
    @(posedge clk);
    #1 in_valid = 1'b0;
    l = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        l = i;
        break;
      end
    end
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_ov_low"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_rdy_high"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_quotient", {16'd0, quotient}, 32'd0);
    chk("rst_remainder", {16'd0, remainder}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    rst_n = 1'b1;

    // 1000 / 7 with the consumer always ready
    out_ready = 1'b1;
    run_op(32'd1000, 16'd7, lat);
    chk("a_latency", lat, LAT_N);
    chk("a_quotient", {16'd0, quotient}, {16'd0, Q_A});
    chk("a_remainder", {16'd0, remainder}, {16'd0, R_A});
    chk("a_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("a_ovf", {31'd0, overflow}, 32'd0);
    @(negedge clk);
    chk("a_ov_low", {31'd0, out_valid}, 32'd0);
    chk("a_rdy_high", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b0;

    // Divide by zero, then held under backpressure with a competing request
    run_op(32'h0000_1234, 16'd0, lat);
    chk("z_latency", lat, 1);
    chk("z_quotient", {16'd0, quotient}, 32'h0000_FFFF);
    chk("z_remainder", {16'd0, remainder}, 32'h0000_1234);
    chk("z_dbz", {31'd0, div_by_zero}, 32'd1);
    chk("z_ovf", {31'd0, overflow}, 32'd0);
    in_valid = 1'b1;
    dividend = 32'h0001_0000;
    divisor  = 16'd1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_quotient", {16'd0, quotient}, 32'h0000_FFFF);
      chk("bp_remainder", {16'd0, remainder}, 32'h0000_1234);
      chk("bp_dbz", {31'd0, div_by_zero}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_idle_ov", {31'd0, out_valid}, 32'd0);
    chk("bp_idle_rdy", {31'd0, in_ready}, 32'd1);
    // Pending request is accepted at the end of this IDLE cycle: overflow case
    @(negedge clk);
    in_valid = 1'b0;
    chk("o_out_valid", {31'd0, out_valid}, 32'd1);
    chk("o_ovf", {31'd0, overflow}, 32'd1);
    chk("o_dbz", {31'd0, div_by_zero}, 32'd0);
    chk("o_quotient", {16'd0, quotient}, 32'h0000_FFFF);
    chk("o_remainder", {16'd0, remainder}, 32'h0000_0000);
    handshake("o");

    // Overflow boundary: high half equal to divisor
    run_op(32'h0005_0000, 16'd5, lat);
    chk("ob_latency", lat, 1);
    chk("ob_ovf", {31'd0, overflow}, 32'd1);
    chk("ob_quotient", {16'd0, quotient}, 32'h0000_FFFF);
    handshake("ob");

    // General operands
    run_op(32'h1234_5678, 16'hABCD, lat);
    chk("b_latency", lat, LAT_N);
    chk("b_quotient", {16'd0, quotient}, {16'd0, Q_B});
    chk("b_remainder", {16'd0, remainder}, {16'd0, R_B});
    chk("b_ovf", {31'd0, overflow}, 32'd0);
    handshake("b");

    // Largest non-overflowing case: needs the extra partial-remainder bit
    run_op(32'hFFFE_FFFF, 16'hFFFF, lat);
    chk("m_latency", lat, LAT_N);
    chk("m_quotient", {16'd0, quotient}, {16'd0, Q_M});
    chk("m_remainder", {16'd0, remainder}, {16'd0, R_M});
    chk("m_ovf", {31'd0, overflow}, 32'd0);
    handshake("m");

    // Reset in the middle of a division
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 32'd1000;
    divisor  = 16'd7;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("mr_busy", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mr_rdy_async", {31'd0, in_ready}, 32'd1);
    chk("mr_ov_async", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("mr_rdy", {31'd0, in_ready}, 32'd1);
    chk("mr_ov", {31'd0, out_valid}, 32'd0);
    chk("mr_quotient", {16'd0, quotient}, 32'd0);
    run_op(32'd1000, 16'd7, lat);
    chk("r_latency", lat, LAT_N);
    chk("r_quotient", {16'd0, quotient}, {16'd0, Q_A});
    chk("r_remainder", {16'd0, remainder}, {16'd0, R_A});
    handshake("r");

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
